// File: rtl/pbit_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module   : pbit_sweep_sched
// Brief    : Sequential p-bit update scheduler. Fires one enable per p-bit with
//            settle gaps, then captures the p-bit vector once per sweep.
//            Optional burn-in sweeps: define PBIT_SCHED_BURNIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pbit_sweep_sched #(
  parameter int NPBIT   = 8,
  parameter int SETTLE  = 2,
  parameter int SWEEP_W = 16,
  parameter int BURNIN  = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic               stop,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic [NPBIT-1:0]   pbit_state,
  output logic [NPBIT-1:0]   en,
  output logic               busy,
  output logic [NPBIT-1:0]   sample_data,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               done,
  output logic               overrun
);

  localparam int               c_IDX_W = (NPBIT > 1) ? $clog2(NPBIT) : 1;
  localparam logic [NPBIT-1:0] c_ONE   = NPBIT'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRE   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [3:0]           r_settle_cnt;
  logic [SWEEP_W-1:0]   r_num_sweeps;
  logic [SWEEP_W-1:0]   r_sweep_count;
  logic [NPBIT-1:0]     r_sample_data;
  logic                 r_sample_valid;
  logic                 r_stop_seen;
  logic                 r_done;
  logic                 r_overrun;

  logic                 w_settle_last;
  logic                 w_last_idx;
  logic                 w_sweep_end;
  logic                 w_burn_active;
  logic                 w_sample_sweep;
  logic                 w_run_end;
  logic [SWEEP_W-1:0]   w_count_inc;

`ifdef PBIT_SCHED_BURNIN_EN
  localparam int c_BURN_W = (BURNIN > 0) ? $clog2(BURNIN + 1) : 1;
  logic [c_BURN_W-1:0] r_burn_cnt;
  assign w_burn_active = (r_burn_cnt != '0);
`else
  // Burn-in compiled out: constant-false for any legal BURNIN.
  assign w_burn_active = (BURNIN < 0);
`endif

  assign w_settle_last  = (r_settle_cnt == 4'(SETTLE - 1));
  assign w_last_idx     = (r_idx == c_IDX_W'(NPBIT - 1));
  assign w_sweep_end    = (r_state == S_SETTLE) && w_settle_last && w_last_idx;
  assign w_sample_sweep = w_sweep_end && !w_burn_active;
  assign w_count_inc    = r_sweep_count + SWEEP_W'(1);
  // Stop arriving on the sweep-end cycle itself also ends the run there.
  assign w_run_end      = w_sample_sweep &&
                          (((r_num_sweeps != '0) && (w_count_inc == r_num_sweeps)) ||
                           r_stop_seen || stop);

  assign en           = (r_state == S_FIRE) ? (c_ONE << r_idx) : '0;
  assign busy         = (r_state != S_IDLE);
  assign sample_data  = r_sample_data;
  assign sample_valid = r_sample_valid;
  assign sweep_count  = r_sweep_count;
  assign done         = r_done;
  assign overrun      = r_overrun;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FIRE;
      S_FIRE:   w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settle_last) w_state_nxt = w_run_end ? S_IDLE : S_FIRE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx          <= '0;
      r_settle_cnt   <= '0;
      r_num_sweeps   <= '0;
      r_sweep_count  <= '0;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
      r_stop_seen    <= 1'b0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
`ifdef PBIT_SCHED_BURNIN_EN
      r_burn_cnt     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_num_sweeps  <= num_sweeps;
        r_sweep_count <= '0;
        r_overrun     <= 1'b0;
        r_stop_seen   <= 1'b0;
        r_idx         <= '0;
        r_settle_cnt  <= '0;
`ifdef PBIT_SCHED_BURNIN_EN
        r_burn_cnt    <= c_BURN_W'(BURNIN);
`endif
      end else begin
        if ((r_state != S_IDLE) && stop) r_stop_seen <= 1'b1;
        if (r_state == S_FIRE) r_settle_cnt <= '0;
        if (r_state == S_SETTLE) begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
          if (w_settle_last) r_idx <= w_last_idx ? '0 : r_idx + c_IDX_W'(1);
        end
`ifdef PBIT_SCHED_BURNIN_EN
        if (w_sweep_end && w_burn_active) r_burn_cnt <= r_burn_cnt - c_BURN_W'(1);
`endif
        if (w_sample_sweep) begin
          r_sweep_count <= w_count_inc;
          if (w_run_end) r_done <= 1'b1;
        end
      end

      if (r_sample_valid && sample_ready) r_sample_valid <= 1'b0;
      // A held, unaccepted sample wins; the fresh vector is dropped.
      if (w_sample_sweep) begin
        if (!r_sample_valid || sample_ready) begin
          r_sample_data  <= pbit_state;
          r_sample_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pbit_sweep_sched.sv
`default_nettype none
// Directed bench for pbit_sweep_sched: enable timing, sample handshake,
// overrun, stop, reset and (with PBIT_SCHED_BURNIN_EN) burn-in.
module tb_pbit_sweep_sched;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sample_ready = 1'b0;
  logic [15:0] num_sweeps = '0;
  logic [7:0]  pbit_state = '0;
  logic [7:0]  en;
  logic        busy;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic [15:0] sweep_count;
  logic        done;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  pbit_sweep_sched #(
    .NPBIT(8), .SETTLE(2), .SWEEP_W(16), .BURNIN(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop),
    .num_sweeps(num_sweeps), .pbit_state(pbit_state), .en(en), .busy(busy),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sweep_count(sweep_count), .done(done),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected enable at cycle c (1-based after start) within a running sweep
  function automatic logic [7:0] en_at(input int c);
    int p;
    p = (c - 1) % 24;
    if (p % 3 == 0) return 8'(1 << (p / 3));
    return 8'h00;
  endfunction

  task automatic kick(input logic [15:0] n);
    num_sweeps = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    chk("rst_en", en, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_count", sweep_count, 16'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    RST_N = 1'b1;
    tick();

`ifdef PBIT_SCHED_BURNIN_EN
    sample_ready = 1'b1;
    pbit_state   = 8'hC3;
    kick(16'd1);
    for (int c = 1; c <= 122; c++) begin
      chk("bi_valid", sample_valid, (c == 121));
      chk("bi_done", done, (c == 121));
      chk("bi_busy", busy, (c <= 120));
      if (c == 120) chk("bi_count120", sweep_count, 16'd0);
      if (c == 121) begin
        chk("bi_count121", sweep_count, 16'd1);
        chk("bi_data", sample_data, 8'hC3);
      end
      tick();
    end
`else
    // Two-sweep run; a mid-run start and num_sweeps change must be ignored
    sample_ready = 1'b1;
    pbit_state   = 8'hA5;
    kick(16'd2);
    for (int c = 1; c <= 50; c++) begin
      chk("t1_en", en, (c <= 48) ? en_at(c) : 8'h00);
      chk("t1_valid", sample_valid, (c == 25 || c == 49));
      chk("t1_done", done, (c == 49));
      chk("t1_busy", busy, (c <= 48));
      if (c == 25) begin
        chk("t1_data1", sample_data, 8'hA5);
        chk("t1_count1", sweep_count, 16'd1);
        pbit_state = 8'h3C;
      end
      if (c == 49) begin
        chk("t1_data2", sample_data, 8'h3C);
        chk("t1_count2", sweep_count, 16'd2);
      end
      if (c == 10) begin
        start      = 1'b1;
        num_sweeps = 16'd5;
      end
      if (c == 11) start = 1'b0;
      tick();
    end

    // Back-pressure: first sample held, later ones dropped with overrun
    sample_ready = 1'b0;
    pbit_state   = 8'hA5;
    kick(16'd3);
    for (int c = 1; c <= 74; c++) begin
      if (c == 25) begin
        chk("t2_valid1", sample_valid, 1'b1);
        chk("t2_data1", sample_data, 8'hA5);
        chk("t2_ovr1", overrun, 1'b0);
        chk("t2_count1", sweep_count, 16'd1);
        pbit_state = 8'h5A;
      end
      if (c == 49) begin
        chk("t2_ovr2", overrun, 1'b1);
        chk("t2_data2", sample_data, 8'hA5);
        chk("t2_valid2", sample_valid, 1'b1);
        chk("t2_count2", sweep_count, 16'd2);
        pbit_state = 8'hFF;
      end
      if (c == 73) begin
        chk("t2_done", done, 1'b1);
        chk("t2_count3", sweep_count, 16'd3);
        chk("t2_data3", sample_data, 8'hA5);
        chk("t2_busy", busy, 1'b0);
      end
      if (c == 74) chk("t2_done_pulse", done, 1'b0);
      tick();
    end
    sample_ready = 1'b1;
    tick();
    chk("t2_drain", sample_valid, 1'b0);

    // Stop in IDLE ignored; free-running run stopped mid-sweep 5
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("t3_idle_stop_busy", busy, 1'b0);
    chk("t3_idle_stop_done", done, 1'b0);
    pbit_state = 8'h11;
    kick(16'd0);
    for (int c = 1; c <= 125; c++) begin
      if (c == 100) begin
        chk("t3_count4", sweep_count, 16'd4);
        stop = 1'b1;
      end
      if (c == 101) stop = 1'b0;
      if (c == 118) chk("t3_en118", en, 8'h80);
      if (c == 120) begin
        chk("t3_busy120", busy, 1'b1);
        chk("t3_done120", done, 1'b0);
      end
      if (c == 121) begin
        chk("t3_done", done, 1'b1);
        chk("t3_count5", sweep_count, 16'd5);
        chk("t3_busy", busy, 1'b0);
        chk("t3_valid", sample_valid, 1'b1);
      end
      if (c > 121) begin
        chk("t3_en_idle", en, 8'h00);
        chk("t3_done_idle", done, 1'b0);
      end
      tick();
    end

    // Asynchronous reset during FIRE of idx 3 in sweep 2
    sample_ready = 1'b0;
    pbit_state   = 8'h96;
    kick(16'd0);
    for (int c = 1; c < 34; c++) tick();
    chk("t4_en_pre", en, 8'h08);
    chk("t4_count_pre", sweep_count, 16'd1);
    chk("t4_valid_pre", sample_valid, 1'b1);
    chk("t4_data_pre", sample_data, 8'h96);
    RST_N = 1'b0;
    #1;
    chk("t4_en", en, 8'h00);
    chk("t4_busy", busy, 1'b0);
    chk("t4_valid", sample_valid, 1'b0);
    chk("t4_data", sample_data, 8'h00);
    chk("t4_count", sweep_count, 16'd0);
    chk("t4_done", done, 1'b0);
    chk("t4_overrun", overrun, 1'b0);
    repeat (2) tick();
    RST_N = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("t4_post_done", done, 1'b0);
      chk("t4_post_busy", busy, 1'b0);
      chk("t4_post_en", en, 8'h00);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
